// File: rtl/pd_seq_pkg.sv
// Shared types and word-field constants for the coil-pattern sequencer.
package pd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PAT_LSB = 0;
    localparam int unsigned DUR_LSB = 16;

    localparam int unsigned DEFAULT_IDLE_PATTERN = 0;

endpackage

// File: rtl/pd_tick_prescaler.sv
// Divides the clock into one-cycle ticks every TICK_DIV cycles; clr restarts the count.
module pd_tick_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pd_pattern_sequencer.sv
// Avalon-MM read master that pops pattern words from the FIFO and holds each
// pattern on the coil-drive output for its programmed number of ticks.
module pd_pattern_sequencer
    import pd_seq_pkg::*;
#(
    parameter int unsigned PAT_W        = 16,
    parameter int unsigned DUR_W        = 16,
    parameter int unsigned TICK_DIV     = 1,
    parameter int unsigned IDLE_PATTERN = DEFAULT_IDLE_PATTERN
) (
    input  logic              pd_clk_clk,
    input  logic              pd_reset_reset,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              ctrl_abort,
    input  logic [15:0]       ctrl_word_count,
    output logic              fifo_read,
    input  logic [31:0]       fifo_readdata,
    input  logic              fifo_waitrequest,
    output logic [PAT_W-1:0]  pattern_out,
    output logic              pattern_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [15:0]       words_played
);

    localparam int unsigned  CNT_W    = 16;
    localparam logic [PAT_W-1:0] IDLE_PAT = PAT_W'(IDLE_PATTERN);

    state_t              state, state_n;
    logic                nxt_valid, nxt_valid_n;
    logic [WORD_W-1:0]   nxt_word;
    logic [CNT_W-1:0]    fetched, fetched_n;
    logic [CNT_W-1:0]    target, target_n;
    logic                stop_pending, stop_n;
    logic [DUR_W-1:0]    dur_cnt;

    logic                tick_c, clr_c, accept_c, read_out_c, last_c, reached_c;
    logic                start_c, load_c, end_c, underrun_c, issue_c;
    logic [WORD_W-1:0]   load_word_c;
    logic [DUR_W-1:0]    load_dur_c;

    assign accept_c    = fifo_read && !fifo_waitrequest;
    assign read_out_c  = fifo_read && fifo_waitrequest;
    assign last_c      = (state == PLAY) && tick_c && (dur_cnt == DUR_W'(1));
    assign reached_c   = (target != '0) && (words_played >= target);
    assign load_word_c = nxt_valid ? nxt_word : fifo_readdata;
    assign load_dur_c  = load_word_c[DUR_LSB +: DUR_W];
    assign clr_c       = load_c || (state != PLAY);

    pd_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (pd_clk_clk),
        .rst    (pd_reset_reset),
        .clr    (clr_c),
        .tick_c (tick_c)
    );

    // Next-state, buffer and fetch bookkeeping; abort overrides everything.
    always_comb begin
        state_n     = state;
        nxt_valid_n = nxt_valid;
        fetched_n   = fetched;
        stop_n      = stop_pending;
        start_c     = 1'b0;
        load_c      = 1'b0;
        end_c       = 1'b0;
        underrun_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ctrl_start && !ctrl_stop && !ctrl_abort) begin
                    start_c     = 1'b1;
                    state_n     = PRIME;
                    fetched_n   = '0;
                    stop_n      = 1'b0;
                    nxt_valid_n = 1'b0;
                end
            end
            PRIME: begin
                if (accept_c) fetched_n = fetched + CNT_W'(1);
                if (ctrl_stop) stop_n = 1'b1;
                if (nxt_valid || accept_c) begin
                    load_c      = 1'b1;
                    nxt_valid_n = 1'b0;
                    state_n     = PLAY;
                end else if (stop_n && !fifo_read) begin
                    end_c   = 1'b1;
                    stop_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            PLAY: begin
                if (accept_c) fetched_n = fetched + CNT_W'(1);
                if (last_c) begin
                    if (stop_pending || ctrl_stop || reached_c) begin
                        end_c       = 1'b1;
                        nxt_valid_n = 1'b0;
                        stop_n      = 1'b0;
                        state_n     = read_out_c ? FLUSH : IDLE;
                    end else if (nxt_valid || accept_c) begin
                        load_c      = 1'b1;
                        nxt_valid_n = 1'b0;
                    end else begin
                        underrun_c = 1'b1;
                        state_n    = PRIME;
                    end
                end else begin
                    if (ctrl_stop) stop_n = 1'b1;
                    if (accept_c) nxt_valid_n = 1'b1;
                end
            end
            FLUSH: begin
                if (accept_c) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (ctrl_abort && (state != IDLE)) begin
            state_n     = read_out_c ? FLUSH : IDLE;
            nxt_valid_n = 1'b0;
            stop_n      = 1'b0;
            load_c      = 1'b0;
            end_c       = 1'b0;
            underrun_c  = 1'b0;
        end
    end

    assign target_n = start_c ? ctrl_word_count : target;
    assign issue_c  = ((state_n == PRIME) || (state_n == PLAY)) && !nxt_valid_n && !stop_n &&
                      ((target_n == '0) || (fetched_n < target_n));

    always_ff @(posedge pd_clk_clk or posedge pd_reset_reset) begin
        if (pd_reset_reset) begin
            state         <= IDLE;
            nxt_valid     <= 1'b0;
            nxt_word      <= '0;
            fetched       <= '0;
            target        <= '0;
            stop_pending  <= 1'b0;
            dur_cnt       <= '0;
            fifo_read     <= 1'b0;
            pattern_out   <= IDLE_PAT;
            pattern_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            underrun      <= 1'b0;
            words_played  <= '0;
        end else begin
            state        <= state_n;
            nxt_valid    <= nxt_valid_n;
            fetched      <= fetched_n;
            target       <= target_n;
            stop_pending <= stop_n;
            fifo_read    <= read_out_c || issue_c;
            busy         <= (state_n != IDLE);
            done         <= end_c;
            if (accept_c) nxt_word <= fifo_readdata;
            if (start_c) begin
                underrun     <= 1'b0;
                words_played <= '0;
            end
            if (underrun_c) underrun <= 1'b1;
            // Word load restarts the duration count; leaving PLAY idles the coil.
            if (load_c) begin
                pattern_out   <= load_word_c[PAT_LSB +: PAT_W];
                pattern_valid <= 1'b1;
                dur_cnt       <= (load_dur_c == '0) ? DUR_W'(1) : load_dur_c;
                if (words_played != 16'hFFFF) words_played <= words_played + 16'd1;
            end else if (state_n != PLAY) begin
                pattern_out   <= IDLE_PAT;
                pattern_valid <= 1'b0;
            end else if (tick_c && (dur_cnt != DUR_W'(1))) begin
                dur_cnt <= dur_cnt - DUR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pd_pattern_sequencer.sv
// Directed bench for pd_pattern_sequencer: playback, underrun, stop, abort, prescale, reset.
module tb_pd_pattern_sequencer;

    logic        clk;
    logic        rst;
    logic        ctrl_start, ctrl_stop, ctrl_abort;
    logic [15:0] ctrl_word_count;
    logic        fifo_read;
    logic [31:0] fifo_readdata;
    logic        fifo_waitrequest;
    logic [15:0] pattern_out;
    logic        pattern_valid, busy, done, underrun;
    logic [15:0] words_played;

    logic        fifo_read4;
    logic [31:0] fifo_readdata4;
    logic        fifo_waitrequest4;
    logic [15:0] pattern_out4;
    logic        pattern_valid4, busy4, done4, underrun4;
    logic [15:0] words_played4;

    logic [31:0] mem [0:7];
    logic [2:0]  rd_ptr;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_readdata = mem[rd_ptr];

    always @(posedge clk or posedge rst) begin
        if (rst) rd_ptr <= 3'd0;
        else if (fifo_read && !fifo_waitrequest) rd_ptr <= rd_ptr + 3'd1;
    end

    pd_pattern_sequencer #(.PAT_W(16), .DUR_W(16), .TICK_DIV(1), .IDLE_PATTERN(0)) dut (
        .pd_clk_clk       (clk),
        .pd_reset_reset   (rst),
        .ctrl_start       (ctrl_start),
        .ctrl_stop        (ctrl_stop),
        .ctrl_abort       (ctrl_abort),
        .ctrl_word_count  (ctrl_word_count),
        .fifo_read        (fifo_read),
        .fifo_readdata    (fifo_readdata),
        .fifo_waitrequest (fifo_waitrequest),
        .pattern_out      (pattern_out),
        .pattern_valid    (pattern_valid),
        .busy             (busy),
        .done             (done),
        .underrun         (underrun),
        .words_played     (words_played)
    );

    pd_pattern_sequencer #(.PAT_W(16), .DUR_W(16), .TICK_DIV(4), .IDLE_PATTERN(0)) dut4 (
        .pd_clk_clk       (clk),
        .pd_reset_reset   (rst),
        .ctrl_start       (ctrl_start),
        .ctrl_stop        (ctrl_stop),
        .ctrl_abort       (ctrl_abort),
        .ctrl_word_count  (ctrl_word_count),
        .fifo_read        (fifo_read4),
        .fifo_readdata    (fifo_readdata4),
        .fifo_waitrequest (fifo_waitrequest4),
        .pattern_out      (pattern_out4),
        .pattern_valid    (pattern_valid4),
        .busy             (busy4),
        .done             (done4),
        .underrun         (underrun4),
        .words_played     (words_played4)
    );

    task automatic clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        ctrl_abort = 1'b0;
        fifo_waitrequest = 1'b0;
        fifo_waitrequest4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] cnt);
        ctrl_word_count = cnt;
        ctrl_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ctrl_start = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        ctrl_start = 1'b0;
        ctrl_stop = 1'b0;
        ctrl_abort = 1'b0;
        ctrl_word_count = 16'd0;
        fifo_waitrequest = 1'b0;
        fifo_waitrequest4 = 1'b0;
        fifo_readdata4 = 32'h0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read got=%b exp=0", fifo_read); end
        checks++; if (pattern_out !== 16'h0) begin errors++; $display("FAIL rst_pattern got=%h exp=0000", pattern_out); end
        checks++; if (pattern_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", pattern_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
        checks++; if (words_played !== 16'h0) begin errors++; $display("FAIL rst_words got=%h exp=0000", words_played); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_playback();
        logic [15:0] exp_pat;
        logic [7:0]  exp_val;
        logic [7:0]  exp_done;
        exp_val  = 8'b0011_1111;
        exp_done = 8'b0100_0000;
        clear_mem();
        mem[0] = 32'h0002_00AA;
        mem[1] = 32'h0001_0055;
        mem[2] = 32'h0003_00F0;
        mem[3] = 32'h0001_0077;
        do_reset();
        pulse_start(16'd3);
        checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL play_first_read got=%b exp=1", fifo_read); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL play_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_pat = (k <= 2) ? 16'h00AA : (k == 3) ? 16'h0055 : (k <= 6) ? 16'h00F0 : 16'h0000;
            checks++; if (pattern_out !== exp_pat) begin errors++; $display("FAIL play_pattern k=%0d got=%h exp=%h", k, pattern_out, exp_pat); end
            checks++; if (pattern_valid !== exp_val[k-1]) begin errors++; $display("FAIL play_valid k=%0d got=%b exp=%b", k, pattern_valid, exp_val[k-1]); end
            checks++; if (done !== exp_done[k-1]) begin errors++; $display("FAIL play_done k=%0d got=%b exp=%b", k, done, exp_done[k-1]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL play_end_busy got=%b exp=0", busy); end
        checks++; if (words_played !== 16'd3) begin errors++; $display("FAIL play_words got=%0d exp=3", words_played); end
        checks++; if (rd_ptr !== 3'd3) begin errors++; $display("FAIL play_reads got=%0d exp=3", rd_ptr); end
    endtask

    task automatic test_underrun();
        logic [15:0] exp_pat;
        logic        exp_val, exp_und;
        clear_mem();
        mem[0] = 32'h0002_0011;
        mem[1] = 32'h0001_0022;
        mem[2] = 32'h0004_0033;
        do_reset();
        pulse_start(16'd0);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_pat = (k <= 2) ? 16'h0011 : (k == 12) ? 16'h0022 : 16'h0000;
            exp_val = (k <= 2) || (k == 12);
            exp_und = (k >= 3) && (k <= 13);
            checks++; if (pattern_out !== exp_pat) begin errors++; $display("FAIL und_pattern k=%0d got=%h exp=%h", k, pattern_out, exp_pat); end
            checks++; if (pattern_valid !== exp_val) begin errors++; $display("FAIL und_valid k=%0d got=%b exp=%b", k, pattern_valid, exp_val); end
            checks++; if (underrun !== exp_und) begin errors++; $display("FAIL und_flag k=%0d got=%b exp=%b", k, underrun, exp_und); end
            if (k <= 11) begin
                checks++; if (fifo_read !== 1'b1) begin errors++; $display("FAIL und_read_held k=%0d got=%b exp=1", k, fifo_read); end
            end
            if (k == 13) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL und_abort_busy got=%b exp=0", busy); end
            end
            if (k == 14) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL und_restart_busy got=%b exp=1", busy); end
            end
            fifo_waitrequest = (k >= 1) && (k < 11);
            ctrl_abort = (k == 12);
            ctrl_start = (k == 13);
        end
        ctrl_start = 1'b0;
    endtask

    task automatic test_stop();
        logic [15:0] exp_pat;
        clear_mem();
        mem[0] = 32'h0001_0001;
        mem[1] = 32'h0005_0002;
        mem[2] = 32'h0001_0003;
        mem[3] = 32'h0001_0004;
        do_reset();
        pulse_start(16'd0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_pat = (k == 1) ? 16'h0001 : (k <= 6) ? 16'h0002 : 16'h0000;
            checks++; if (pattern_out !== exp_pat) begin errors++; $display("FAIL stop_pattern k=%0d got=%h exp=%h", k, pattern_out, exp_pat); end
            checks++; if (done !== (k == 7)) begin errors++; $display("FAIL stop_done k=%0d got=%b exp=%b", k, done, (k == 7)); end
            if (k >= 3) begin
                checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL stop_no_read k=%0d got=%b exp=0", k, fifo_read); end
            end
            ctrl_stop = (k == 3);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
        checks++; if (rd_ptr !== 3'd3) begin errors++; $display("FAIL stop_reads got=%0d exp=3", rd_ptr); end
        checks++; if (words_played !== 16'd2) begin errors++; $display("FAIL stop_words got=%0d exp=2", words_played); end
    endtask

    task automatic test_abort_stalled();
        clear_mem();
        mem[0] = 32'h0003_000A;
        mem[1] = 32'h0001_00BB;
        do_reset();
        pulse_start(16'd0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (pattern_valid !== (k == 1)) begin errors++; $display("FAIL abort_valid k=%0d got=%b exp=%b", k, pattern_valid, (k == 1)); end
            checks++; if (pattern_out !== ((k == 1) ? 16'h000A : 16'h0000)) begin errors++; $display("FAIL abort_pattern k=%0d got=%h", k, pattern_out); end
            checks++; if (busy !== (k <= 4)) begin errors++; $display("FAIL abort_busy k=%0d got=%b exp=%b", k, busy, (k <= 4)); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done k=%0d got=%b exp=0", k, done); end
            checks++; if (fifo_read !== (k <= 4)) begin errors++; $display("FAIL abort_read k=%0d got=%b exp=%b", k, fifo_read, (k <= 4)); end
            ctrl_abort = (k == 1);
            fifo_waitrequest = (k >= 1) && (k < 4);
        end
        checks++; if (rd_ptr !== 3'd2) begin errors++; $display("FAIL abort_reads got=%0d exp=2", rd_ptr); end
        checks++; if (words_played !== 16'd1) begin errors++; $display("FAIL abort_words got=%0d exp=1", words_played); end
    endtask

    task automatic test_prescale();
        clear_mem();
        fifo_readdata4 = 32'h0000_00C3;
        do_reset();
        pulse_start(16'd1);
        checks++; if (fifo_read4 !== 1'b1) begin errors++; $display("FAIL tick4_read got=%b exp=1", fifo_read4); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (pattern_out4 !== ((k <= 4) ? 16'h00C3 : 16'h0000)) begin errors++; $display("FAIL tick4_pattern k=%0d got=%h", k, pattern_out4); end
            checks++; if (pattern_valid4 !== (k <= 4)) begin errors++; $display("FAIL tick4_valid k=%0d got=%b exp=%b", k, pattern_valid4, (k <= 4)); end
            checks++; if (done4 !== (k == 5)) begin errors++; $display("FAIL tick4_done k=%0d got=%b exp=%b", k, done4, (k == 5)); end
        end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL tick4_busy got=%b exp=0", busy4); end
        checks++; if (words_played4 !== 16'd1) begin errors++; $display("FAIL tick4_words got=%0d exp=1", words_played4); end
        checks++; if (underrun4 !== 1'b0) begin errors++; $display("FAIL tick4_underrun got=%b exp=0", underrun4); end
    endtask

    task automatic test_async_reset();
        clear_mem();
        mem[0] = 32'h0004_00AA;
        mem[1] = 32'h0004_0055;
        do_reset();
        pulse_start(16'd0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (pattern_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got=%b exp=1", pattern_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (fifo_read !== 1'b0) begin errors++; $display("FAIL areset_fifo_read got=%b exp=0", fifo_read); end
        checks++; if (pattern_out !== 16'h0) begin errors++; $display("FAIL areset_pattern got=%h exp=0000", pattern_out); end
        checks++; if (pattern_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%b exp=0", pattern_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", done); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL areset_underrun got=%b exp=0", underrun); end
        checks++; if (words_played !== 16'h0) begin errors++; $display("FAIL areset_words got=%h exp=0000", words_played); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_playback();
        test_underrun();
        test_stop();
        test_abort_stalled();
        test_prescale();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
